// File: rtl/eva_intr_pkg.sv
// eva_intr_pkg: shared definitions for the EVA interrupt controller.
//   - Word offsets (haddr[4:2]) of the register map.
//   - AHB hresp encodings and the only legal hsize.
//   - Error-response FSM state enum.
//   - IRQ_ID_NONE, reported on irq_id when no STATUS bit is set.
//   - lowest_set_idx(): priority encoder, lowest index wins.
package eva_intr_pkg;

    localparam logic [2:0] OFF_RAW      = 3'd0;
    localparam logic [2:0] OFF_MODE     = 3'd1;
    localparam logic [2:0] OFF_POL      = 3'd2;
    localparam logic [2:0] OFF_EN       = 3'd3;
    localparam logic [2:0] OFF_PEND     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;
    localparam logic [2:0] OFF_SWSET    = 3'd6;
    localparam logic [2:0] OFF_UNMAPPED = 3'd7;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [5:0] IRQ_ID_NONE = 6'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } bus_state_e;

    // Index of the lowest set bit of vec, IRQ_ID_NONE when vec is zero.
    function automatic logic [5:0] lowest_set_idx(input logic [31:0] vec);
        logic [5:0] idx;
        idx = IRQ_ID_NONE;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 6'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/eva_intr_ctrl_sync.sv
// eva_sync_bus: per-bit flop-chain synchroniser for asynchronous inputs.
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears every stage
//   d    - asynchronous input bus (W bits)
//   q    - synchronised output, STAGES clock edges after d
module eva_sync_bus #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stage_r;

    // Shift chain: stage 0 samples the raw input, the last stage is the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[STAGES-2:0], d};
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/eva_intr_ctrl.sv
// eva_intr_ctrl: parametrised interrupt controller with an AHB-lite slave.
//   hclk / hrst            - sole clock, async active-high reset
//   hsel, htrans, hwrite,
//   haddr, hsize, hwdata,
//   hready_in              - AHB-lite slave inputs (haddr[4:2] decoded)
//   hready_out, hresp,
//   hrdata                 - AHB-lite slave outputs (OKAY zero-wait, ERROR two-cycle)
//   intr_in                - NUM_CH asynchronous interrupt sources
//   irq                    - registered OR of STATUS = PEND & EN
//   irq_id                 - registered lowest set STATUS index, 6'h3F if none
module eva_intr_ctrl
    import eva_intr_pkg::*;
#(
    parameter int NUM_CH      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [31:0]       haddr,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready_in,
    output logic              hready_out,
    output logic [1:0]        hresp,
    output logic [31:0]       hrdata,
    input  logic [NUM_CH-1:0] intr_in,
    output logic              irq,
    output logic [5:0]        irq_id
);

    logic [NUM_CH-1:0] sync_s;
    logic [NUM_CH-1:0] lvl_s;
    logic [NUM_CH-1:0] lvl_d_r;
    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0] pol_r;
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] pend_r;
    logic [NUM_CH-1:0] pend_nxt_s;
    logic [NUM_CH-1:0] status_s;
    logic [NUM_CH-1:0] w1c_s;
    logic [NUM_CH-1:0] swset_s;
    logic [NUM_CH-1:0] wdata_s;
    logic [31:0]       status_ext_s;
    logic [31:0]       rdata_s;

    logic              accept_s;
    logic              err_s;
    logic              commit_s;
    logic              dphase_r;
    logic              wr_r;
    logic [2:0]        off_r;

    logic              irq_r;
    logic [5:0]        irq_id_r;

    bus_state_e        state_r;
    bus_state_e        state_nxt_s;

    logic              unused_s;

    // Address bits outside [4:2], htrans[0] and hwdata bits above NUM_CH carry no meaning here.
    assign unused_s = ^{haddr[31:5], haddr[1:0], htrans[0], hwdata};

    eva_sync_bus #(
        .W      (NUM_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (hclk),
        .rst (hrst),
        .d   (intr_in),
        .q   (sync_s)
    );

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
    assign lvl_s    = sync_s ^ pol_r;
    assign rise_s   = lvl_s & ~lvl_d_r;
    assign status_s = pend_r & en_r;

    // One-cycle delayed level for rising-edge detection.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            lvl_d_r <= '0;
        end else begin
            lvl_d_r <= lvl_s;
        end
    end

    // ------------------------------------------------------------------
    // AHB address phase
    // ------------------------------------------------------------------
    assign accept_s = hsel & htrans[1] & hready_in;
    assign commit_s = dphase_r & wr_r;
    assign wdata_s  = hwdata[NUM_CH-1:0];

    // Error decode on the address phase: unmapped offset, bad size, write to a read-only offset.
    always_comb begin
        err_s = 1'b0;
        if (hsize != HSIZE_WORD) begin
            err_s = 1'b1;
        end else if (haddr[4:2] == OFF_UNMAPPED) begin
            err_s = 1'b1;
        end else if (hwrite && ((haddr[4:2] == OFF_RAW) || (haddr[4:2] == OFF_STATUS))) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Capture the address phase; only error-free transfers open an OKAY data phase.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            dphase_r <= 1'b0;
            wr_r     <= 1'b0;
            off_r    <= 3'd0;
        end else if (accept_s) begin
            dphase_r <= ~err_s;
            wr_r     <= hwrite;
            off_r    <= haddr[4:2];
        end else begin
            dphase_r <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // Configuration registers, written at the edge ending the data phase.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            mode_r <= '0;
            pol_r  <= '0;
            en_r   <= '0;
        end else if (commit_s) begin
            case (off_r)
                OFF_MODE: mode_r <= wdata_s;
                OFF_POL:  pol_r  <= wdata_s;
                OFF_EN:   en_r   <= wdata_s;
                default:  en_r   <= en_r;
            endcase
        end
    end

    // Write-one-to-clear and write-one-to-set strobes into PEND.
    always_comb begin
        w1c_s   = '0;
        swset_s = '0;
        if (commit_s && (off_r == OFF_PEND)) begin
            w1c_s = wdata_s;
        end else if (commit_s && (off_r == OFF_SWSET)) begin
            swset_s = wdata_s;
        end else begin
            w1c_s   = '0;
            swset_s = '0;
        end
    end

    // Level channels track lvl; edge channels latch rise/SWSET with set winning over W1C.
    assign pend_nxt_s = (mode_r & ((pend_r & ~w1c_s) | rise_s | swset_s)) |
                        (~mode_r & lvl_s);

    // Pending register.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Zero-extend STATUS for the 32-bit priority encoder.
    always_comb begin
        status_ext_s               = 32'h0000_0000;
        status_ext_s[NUM_CH-1:0]   = status_s;
    end

    // Aggregate interrupt outputs, one edge behind PEND/EN.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            irq_r    <= 1'b0;
            irq_id_r <= IRQ_ID_NONE;
        end else begin
            irq_r    <= |status_s;
            irq_id_r <= lowest_set_idx(status_ext_s);
        end
    end

    assign irq    = irq_r;
    assign irq_id = irq_id_r;

    // Read mux: live register values during an OKAY read data phase, zero otherwise.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (dphase_r && !wr_r) begin
            case (off_r)
                OFF_RAW:    rdata_s[NUM_CH-1:0] = lvl_s;
                OFF_MODE:   rdata_s[NUM_CH-1:0] = mode_r;
                OFF_POL:    rdata_s[NUM_CH-1:0] = pol_r;
                OFF_EN:     rdata_s[NUM_CH-1:0] = en_r;
                OFF_PEND:   rdata_s[NUM_CH-1:0] = pend_r;
                OFF_STATUS: rdata_s[NUM_CH-1:0] = status_s;
                default:    rdata_s             = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign hrdata = rdata_s;

    // ------------------------------------------------------------------
    // Error-response FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: an errored transfer may be accepted in ERR2 since hready_out is high there.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s && err_s) begin
                    state_nxt_s = ERR1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ERR1: state_nxt_s = ERR2;
            ERR2: begin
                if (accept_s && err_s) begin
                    state_nxt_s = ERR1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Response outputs decoded from the state register.
    always_comb begin
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        case (state_r)
            IDLE: begin
                hready_out = 1'b1;
                hresp      = HRESP_OKAY;
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ERR2: begin
                hready_out = 1'b1;
                hresp      = HRESP_ERROR;
            end
            default: begin
                hready_out = 1'b1;
                hresp      = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: tb/tb_eva_intr_ctrl.sv
// Self-checking bench for eva_intr_ctrl: one NUM_CH=32 instance and one
// NUM_CH=8 instance share the bus; directed vectors with hand-computed results.
module tb_eva_intr_ctrl;

    logic        hclk = 1'b0;
    logic        hrst = 1'b1;
    logic        hsel32 = 1'b0;
    logic        hsel8 = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = 32'h0;
    logic        hready_in;
    logic        tgt8 = 1'b0;

    logic        ho32, ho8;
    logic [1:0]  hr32, hr8;
    logic [31:0] rd32, rd8;
    logic [31:0] intr32 = 32'h0;
    logic [7:0]  intr8 = 8'h0;
    logic        irq32, irq8;
    logic [5:0]  id32, id8;

    int checks = 0;
    int failures = 0;

    assign hready_in = tgt8 ? ho8 : ho32;

    always #5 hclk = ~hclk;

    eva_intr_ctrl dut32 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel32), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
        .hready_out(ho32), .hresp(hr32), .hrdata(rd32), .intr_in(intr32),
        .irq(irq32), .irq_id(id32)
    );

    eva_intr_ctrl #(.NUM_CH(8)) dut8 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel8), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
        .hready_out(ho8), .hresp(hr8), .hrdata(rd8), .intr_in(intr8),
        .irq(irq8), .irq_id(id8)
    );

    localparam logic [31:0] A_RAW = 32'h00, A_MODE = 32'h04, A_POL = 32'h08, A_EN = 32'h0C;
    localparam logic [31:0] A_PEND = 32'h10, A_STATUS = 32'h14, A_SWSET = 32'h18, A_BAD = 32'h1C;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transfer; stalls counts data-phase cycles with hready low.
    task automatic xfer(input logic t8, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        output logic [31:0] rdata, output logic [1:0] resp, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        rdata = 32'h0;
        resp = 2'b00;
        @(posedge hclk); #1;
        tgt8 = t8; hsel32 = ~t8; hsel8 = t8; htrans = 2'b10;
        hwrite = wr; haddr = addr; hsize = size;
        @(posedge hclk); #1;
        hsel32 = 1'b0; hsel8 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = 32'h0; hsize = 3'b010; hwdata = wdata;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge hclk);
            rdata = t8 ? rd8 : rd32;
            resp  = t8 ? hr8 : hr32;
            if (hready_in) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout: addr 0x%08h got no hready within 8 cycles, expected ready", addr);
        end
        @(posedge hclk);
    endtask

    task automatic wr(input logic t8, input logic [31:0] addr, input logic [31:0] data, input string name);
        logic [31:0] r; logic [1:0] s; int st;
        xfer(t8, 1'b1, addr, data, 3'b010, r, s, st);
        check({name, "_resp"}, {30'd0, s}, 32'd0);
    endtask

    task automatic rd(input logic t8, input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] r; logic [1:0] s; int st;
        xfer(t8, 1'b0, addr, 32'h0, 3'b010, r, s, st);
        check(name, r, exp);
    endtask

    task automatic settle();
        repeat (2) @(negedge hclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r; logic [1:0] s; int st;

        for (int i = 0; i < 7; i++) vecs[i] = '{1'b0, 32'(i * 4), 32'h0, 3'b010, 32'h0, 2'b00};
        vecs[7]  = '{1'b1, A_MODE,   32'h0000_00F0, 3'b010, 32'h0, 2'b00};
        vecs[8]  = '{1'b0, A_MODE,   32'h0,         3'b010, 32'h0000_00F0, 2'b00};
        vecs[9]  = '{1'b1, A_MODE,   32'h0,         3'b000, 32'h0, 2'b01};
        vecs[10] = '{1'b0, A_MODE,   32'h0,         3'b010, 32'h0000_00F0, 2'b00};
        vecs[11] = '{1'b1, A_MODE,   32'h0,         3'b010, 32'h0, 2'b00};
        vecs[12] = '{1'b0, A_MODE,   32'h0,         3'b010, 32'h0, 2'b00};
        vecs[13] = '{1'b0, A_BAD,    32'h0,         3'b010, 32'h0, 2'b01};
        vecs[14] = '{1'b1, A_RAW,    32'hFFFF_FFFF, 3'b010, 32'h0, 2'b01};
        vecs[15] = '{1'b1, A_STATUS, 32'hFFFF_FFFF, 3'b010, 32'h0, 2'b01};
        vecs[16] = '{1'b0, A_RAW,    32'h0,         3'b010, 32'h0, 2'b00};
        vecs[17] = '{1'b0, A_EN,     32'h0,         3'b001, 32'h0, 2'b01};
        vecs[18] = '{1'b1, A_EN,     32'h0000_00FF, 3'b011, 32'h0, 2'b01};
        vecs[19] = '{1'b0, A_EN,     32'h0,         3'b010, 32'h0, 2'b00};
        vecs[20] = '{1'b0, A_SWSET,  32'h0,         3'b010, 32'h0, 2'b00};

        // Reset state
        repeat (3) @(posedge hclk);
        #1 hrst = 1'b0;
        @(negedge hclk);
        check("rst_irq", {31'd0, irq32}, 32'd0);
        check("rst_irq_id", {26'd0, id32}, 32'h3F);
        check("rst_hready", {31'd0, ho32}, 32'd1);
        check("rst_hresp", {30'd0, hr32}, 32'd0);
        check("rst_hrdata", rd32, 32'd0);
        check("rst_irq_id8", {26'd0, id8}, 32'h3F);

        // Table-driven register and error-response vectors
        for (int i = 0; i < NV; i++) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, r, s, st);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            check($sformatf("vec%0d_resp", i), {30'd0, s}, {30'd0, vecs[i].exp_resp});
            check($sformatf("vec%0d_stalls", i), 32'(st), (vecs[i].exp_resp == 2'b01) ? 32'd1 : 32'd0);
        end

        // Level mode timing
        wr(1'b0, A_EN, 32'h5, "lvl_en");
        @(posedge hclk); #1 intr32[2] = 1'b1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("lvl_irq_n2", {31'd0, irq32}, 32'd0);
        @(posedge hclk); @(negedge hclk);
        check("lvl_irq_n3", {31'd0, irq32}, 32'd1);
        check("lvl_id_n3", {26'd0, id32}, 32'd2);
        rd(1'b0, A_PEND, 32'h4, "lvl_pend");
        rd(1'b0, A_STATUS, 32'h4, "lvl_status");
        rd(1'b0, A_RAW, 32'h4, "lvl_raw");

        // EN write reaches irq one edge after commit
        wr(1'b0, A_EN, 32'h0, "en_off");
        @(negedge hclk);
        check("en_off_irq_same", {31'd0, irq32}, 32'd1);
        @(negedge hclk);
        check("en_off_irq_next", {31'd0, irq32}, 32'd0);
        wr(1'b0, A_EN, 32'h5, "en_on");
        settle();
        check("en_on_irq", {31'd0, irq32}, 32'd1);

        // Masked channel pends but does not reach STATUS
        @(posedge hclk); #1 intr32[1] = 1'b1;
        repeat (4) @(posedge hclk);
        rd(1'b0, A_PEND, 32'h6, "mask_pend");
        rd(1'b0, A_STATUS, 32'h4, "mask_status");
        check("mask_id", {26'd0, id32}, 32'd2);

        // Drop inputs: PEND falls at N+2, irq at N+3
        @(posedge hclk); #1 intr32[2:1] = 2'b00;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("drop_irq_n2", {31'd0, irq32}, 32'd1);
        @(posedge hclk); @(negedge hclk);
        check("drop_irq_n3", {31'd0, irq32}, 32'd0);
        check("drop_id_n3", {26'd0, id32}, 32'h3F);

        // Edge mode: pulse is latched, W1C clears
        wr(1'b0, A_MODE, 32'hFFFF_FFFF, "edge_mode");
        wr(1'b0, A_EN, 32'hFFFF_FFFF, "edge_en");
        @(posedge hclk); #1 intr32[7] = 1'b1;
        repeat (2) @(posedge hclk);
        #1 intr32[7] = 1'b0;
        repeat (4) @(posedge hclk);
        @(negedge hclk);
        check("edge_irq", {31'd0, irq32}, 32'd1);
        check("edge_id", {26'd0, id32}, 32'd7);
        rd(1'b0, A_PEND, 32'h80, "edge_pend_held");
        wr(1'b0, A_PEND, 32'h80, "edge_w1c");
        rd(1'b0, A_PEND, 32'h0, "edge_pend_cleared");
        settle();
        check("edge_irq_cleared", {31'd0, irq32}, 32'd0);

        // W1C on the same edge as a new rise: set wins
        @(posedge hclk); #1 intr32[7] = 1'b1;
        wr(1'b0, A_PEND, 32'h80, "coinc_w1c");
        rd(1'b0, A_PEND, 32'h80, "coinc_pend");
        #1 intr32[7] = 1'b0;

        // SWSET on edge channels and lowest-index priority
        wr(1'b0, A_SWSET, 32'h8000_0A00, "swset");
        rd(1'b0, A_PEND, 32'h8000_0A80, "swset_pend");
        check("prio_id7", {26'd0, id32}, 32'd7);
        wr(1'b0, A_PEND, 32'h80, "w1c_7");
        settle();
        check("prio_id9", {26'd0, id32}, 32'd9);
        wr(1'b0, A_PEND, 32'h0000_0A00, "w1c_9_11");
        settle();
        check("prio_id31", {26'd0, id32}, 32'd31);
        wr(1'b0, A_PEND, 32'h8000_0000, "w1c_31");
        settle();
        check("prio_none_irq", {31'd0, irq32}, 32'd0);
        check("prio_none_id", {26'd0, id32}, 32'h3F);

        // Back-to-back write then read of EN, no stall
        @(posedge hclk); #1;
        tgt8 = 1'b0; hsel32 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = A_EN; hsize = 3'b010;
        @(posedge hclk); #1;
        hwrite = 1'b0; hwdata = 32'h0000_1234;
        @(negedge hclk);
        check("b2b_wr_ready", {31'd0, ho32}, 32'd1);
        @(posedge hclk); #1;
        hsel32 = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        check("b2b_rd_data", rd32, 32'h0000_1234);
        check("b2b_rd_ready", {31'd0, ho32}, 32'd1);
        @(posedge hclk);

        // Polarity in level mode; SWSET ignored on level channels
        wr(1'b0, A_MODE, 32'h0, "pol_mode");
        wr(1'b0, A_EN, 32'h0, "pol_en");
        wr(1'b0, A_POL, 32'h1, "pol_set");
        rd(1'b0, A_RAW, 32'h1, "pol_raw");
        rd(1'b0, A_PEND, 32'h1, "pol_pend");
        wr(1'b0, A_SWSET, 32'h2, "lvl_swset");
        rd(1'b0, A_PEND, 32'h1, "lvl_swset_pend");
        wr(1'b0, A_POL, 32'h0, "pol_clr");
        rd(1'b0, A_PEND, 32'h0, "pol_clr_pend");

        // NUM_CH=8 instance: upper bits read 0, priority
        wr(1'b1, A_EN, 32'hFFFF_FFFF, "n8_en");
        rd(1'b1, A_EN, 32'h0000_00FF, "n8_en_rd");
        @(posedge hclk); #1 intr8 = 8'h28;
        repeat (4) @(posedge hclk);
        @(negedge hclk);
        check("n8_irq", {31'd0, irq8}, 32'd1);
        check("n8_id", {26'd0, id8}, 32'd3);
        rd(1'b1, A_STATUS, 32'h28, "n8_status");
        wr(1'b1, A_MODE, 32'hFFFF_FF00, "n8_mode");
        rd(1'b1, A_MODE, 32'h0, "n8_mode_rd");

        // Reset asserted during ERR1
        wr(1'b0, A_EN, 32'h5, "rst_en");
        @(posedge hclk); #1;
        tgt8 = 1'b0; hsel32 = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = A_BAD; hsize = 3'b010;
        @(posedge hclk); #1;
        hsel32 = 1'b0; htrans = 2'b00; haddr = 32'h0;
        check("err1_hready", {31'd0, ho32}, 32'd0);
        check("err1_hresp", {30'd0, hr32}, 32'd1);
        hrst = 1'b1;
        #1;
        check("rst_err_hready", {31'd0, ho32}, 32'd1);
        check("rst_err_hresp", {30'd0, hr32}, 32'd0);
        @(posedge hclk); #1 hrst = 1'b0;
        rd(1'b0, A_EN, 32'h0, "post_rst_en");
        check("post_rst_id", {26'd0, id32}, 32'h3F);
        rd(1'b1, A_EN, 32'h0, "post_rst_en8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eva_intr_ctrl.md
# eva_intr_ctrl

Parametrised interrupt controller for the EVA bench and DUT-side integration, succeeding the fixed 32-bit single-mode interrupt monitor. It samples `NUM_CH` asynchronous interrupt sources, supports per-channel level/edge mode and polarity, and latches pending state with write-1-to-clear. It also drives a masked aggregate `irq` plus a lowest-index-wins `irq_id`. Registers are reached through an AHB-lite slave on the `hclk` domain.

## Interface
- `NUM_CH`, 32, interrupt channel count, 1..32; register bits `[31:NUM_CH]` read 0 and ignore writes.
- `SYNC_STAGES`, 2, synchroniser flops per source, 2..4.
- `hclk`  in  1  sole clock; all logic on its rising edge.
- `hrst`  in  1  reset, asynchronous assert, active-high; synchronous deassert is supplied externally.
- `hsel`  in  1  AHB slave select.
- `htrans`  in  2  AHB transfer type; NONSEQ/SEQ are valid, IDLE/BUSY are ignored.
- `hwrite`  in  1  1 = write.
- `haddr`  in  32  byte address; bits `[4:2]` decoded.
- `hsize`  in  3  only 3'b010 is legal; other values get an ERROR response.
- `hwdata`  in  32  write data, data phase.
- `hready_in`  in  1  bus-level HREADY.
- `hready_out`  out  1  slave ready.
- `hresp`  out  2  2'b00 OKAY, 2'b01 ERROR.
- `hrdata`  out  32  read data, data phase.
- `intr_in`  in  `NUM_CH`  asynchronous interrupt sources.
- `irq`  out  1  registered OR of `STATUS`.
- `irq_id`  out  6  registered index of the lowest set `STATUS` bit; 6'h3F when none.

## Operation
- Register map (word offsets):
  - 0x00 `RAW` (RO): synchronised, polarity-corrected level.
  - 0x04 `MODE` (RW): 0 = level, 1 = edge.
  - 0x08 `POL` (RW): 1 = invert input.
  - 0x0C `EN` (RW).
  - 0x10 `PEND` (RO read, W1C).
  - 0x14 `STATUS` (RO) = `PEND & EN`.
  - 0x18 `SWSET` (WO, reads 0): W1S into `PEND` for edge channels.
  - 0x1C is unmapped and returns ERROR.
- Conditioned level: `lvl[i] = sync[i] ^ POL[i]`.
- Edge detect: `rise[i] = lvl[i] & ~lvl_d[i]`, using a one-cycle delayed copy.
- Level channel: `PEND[i]` <= `lvl[i]` every cycle. W1C and SWSET have no effect.
- Edge channel: `PEND[i]` is set by `rise[i]` or an SWSET bit, and cleared by a W1C bit. If set and clear occur on the same edge, set wins.
- Changing `MODE` or `POL` does not clear `PEND`. A `POL` toggle can create a `rise`, and that rise is legal and latched.
- The `irq_id` priority encoder is combinational over `STATUS`, with the result registered.
- AHB transfer acceptance: a transfer is accepted when `hsel & htrans[1] & hready_in`. The address phase captures `haddr[4:2]`, `hwrite` and an error flag. The error flag is set for offset 0x1C, for `hsize` != 3'b010, and for a write to a RO offset.
- Accepted OKAY transfer: zero wait states.
  - Write commits at the rising edge ending the data phase.
  - `hrdata` is combinational from the captured offset during the data phase and is 0 outside it.
- ERROR response is a two-cycle FSM with states `IDLE`, `ERR1`, `ERR2`:
  - `ERR1`: `hready_out`=0, `hresp`=ERROR.
  - `ERR2`: `hready_out`=1, `hresp`=ERROR.
  - Then back to `IDLE`. An errored write does not modify any register.
- Reset values:
  - `MODE`, `POL`, `EN`, `PEND`, synchroniser and `lvl_d` all 0.
  - `irq`=0, `irq_id`=6'h3F, `hready_out`=1, `hresp`=2'b00, `hrdata`=0, FSM = `IDLE`.

## Timing
- `intr_in` stable before edge N: `lvl` is valid after edge N+SYNC_STAGES-1, and `PEND` updates at edge N+SYNC_STAGES.
- `irq` and `irq_id` update one edge after `PEND`/`EN` change.
- Write-to-`EN` takes effect on `irq` one edge after the write commits.
- Back-to-back write then read of the same offset: the read returns the new value, with no stall.
- W1C of an edge bit in the cycle its `rise` occurs: the bit stays 1.
- `hrst` asserted mid-transfer: all state returns to reset values immediately. The in-flight transfer is dropped, with no response owed.

## Structure
- Package `eva_intr_pkg`: register offset constants, `hresp` encodings, the FSM state enum, and `IRQ_ID_NONE` = 6'h3F.
- Sub-module `eva_sync_bus #(W, STAGES)`: the per-bit flop-chain synchroniser, instantiated once with `W=NUM_CH`.
- Total RTL is about 250 lines.

## Test plan
- Reset, then read all offsets -> all 0. `irq`=0, `irq_id`=0x3F, `hready_out`=1.
- Level mode: `EN`=0x5, `intr_in[2]`=1 -> `PEND`=0x4 at N+2, `irq`=1 and `irq_id`=2 at N+3. Drop the input -> `PEND`=0 and `irq`=0 two and three edges later.
- Edge mode: `MODE`=0xFFFFFFFF, pulse `intr_in[7]` -> `PEND[7]` stays 1 after the input falls. Write `PEND`=0x80 -> 0. W1C coincident with a new rise -> stays 1.
- `POL`=0x1 with `intr_in[0]`=0 in level mode -> `RAW[0]`=1, `PEND[0]`=1. `SWSET`=0x1 on a level channel -> no change.
- `NUM_CH`=8: write 0xFFFFFFFF to `EN` -> reads 0x000000FF. Set `STATUS` bits 3 and 5 -> `irq_id`=3.
- Read offset 0x1C, a write to `RAW`, and `hsize`=3'b000 -> each gives ERROR with exactly one `hready_out`=0 cycle. `RAW`, `MODE` and the other registers are unchanged. Assert `hrst` during `ERR1` -> `hready_out`=1, `hresp`=OKAY immediately.
